// File: rtl/or32.sv
// Bitwise OR slice for the ALU: combinational R = A | B with zero/ones flags,
// plus a registered copy (R_q, zero_q, valid_q) for pipelined consumers.

module or32_bit (
   input  logic a_i,
   input  logic b_i,
   output logic r_o
);
   assign r_o = a_i | b_i;
endmodule

module or32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             en,
   output logic [WIDTH-1:0] R,
   output logic             zero,
   output logic             ones,
   output logic [WIDTH-1:0] R_q,
   output logic             zero_q,
   output logic             valid_q
);

   logic [WIDTH-1:0] r_d;
   logic             zero_d;
   logic             valid_d;

   // One gate-level OR cell per bit; no clk/rst anywhere on this path.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      or32_bit u_bit (
         .a_i (A[i]),
         .b_i (B[i]),
         .r_o (R[i])
      );
   end

   assign zero = ~|R;
   assign ones = &R;

   always_comb begin
      r_d     = R_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      if (en) begin
         r_d     = R;
         zero_d  = zero;
         valid_d = 1'b1;
      end
   end

   // zero_q resets high so it stays consistent with the cleared R_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         R_q     <= '0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         R_q     <= r_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_or32.sv
// Scoreboard bench for or32: stimulus pushes hand-computed expectations,
// a separate monitor pops and compares them against the DUT outputs.

module tb_or32;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic        en;
   logic [31:0] R;
   logic        zero;
   logic        ones;
   logic [31:0] R_q;
   logic        zero_q;
   logic        valid_q;
   logic        clk_run;

   or32 #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .en      (en),
      .R       (R),
      .zero    (zero),
      .ones    (ones),
      .R_q     (R_q),
      .zero_q  (zero_q),
      .valid_q (valid_q)
   );

   typedef struct {
      string       name;
      logic [31:0] r;
      logic        z;
      logic        o;
      logic        chk_reg;
      logic [31:0] rq;
      logic        zq;
      logic        vq;
   } exp_t;

   exp_t sb[$];
   event chk_ev;
   int   errors = 0;
   int   checks = 0;

   initial begin
      clk_run = 1'b0;
      wait (clk_run === 1'b1);
      forever #5 clk = ~clk;
   end

   function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Monitor: consumes every pending expectation each time the stimulus
   // signals that the DUT outputs are presenting a settled response.
   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.name, ".R"},    R,    e.r);
            cmp({e.name, ".zero"}, {31'b0, zero}, {31'b0, e.z});
            cmp({e.name, ".ones"}, {31'b0, ones}, {31'b0, e.o});
            if (e.chk_reg) begin
               cmp({e.name, ".R_q"},     R_q, e.rq);
               cmp({e.name, ".zero_q"},  {31'b0, zero_q},  {31'b0, e.zq});
               cmp({e.name, ".valid_q"}, {31'b0, valid_q}, {31'b0, e.vq});
            end
         end
      end
   end

   task automatic expect_resp(string nm, logic [31:0] r, logic z, logic o,
                              logic cr, logic [31:0] rq, logic zq, logic vq);
      exp_t e;
      e.name = nm; e.r = r; e.z = z; e.o = o;
      e.chk_reg = cr; e.rq = rq; e.zq = zq; e.vq = vq;
      sb.push_back(e);
      -> chk_ev;
      #1;
   endtask

   task automatic comb(string nm, logic [31:0] a, logic [31:0] b,
                       logic [31:0] r, logic z, logic o);
      A = a;
      B = b;
      #1;
      expect_resp(nm, r, z, o, 1'b0, '0, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      logic        o;
   } vec_t;

   vec_t vecs[4];

   initial begin
      clk = 1'bx;
      rst = 1'bx;
      en  = 1'b0;

      // Combinational path with clk and rst left unknown.
      comb("split", 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
      #100;
      vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[3] = '{32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++)
         comb($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r,
              vecs[i].z, vecs[i].o);

      // Reset state of the registered path.
      rst = 1'b1;
      clk = 1'b0;
      #1;
      expect_resp("reset", 32'h12345678, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      clk_run = 1'b1;

      // Load then hold.
      @(negedge clk);
      en = 1'b1; A = 32'h0F0F0F0F; B = 32'hF0000000;
      @(posedge clk); #1;
      expect_resp("load", 32'hFF0F0F0F, 1'b0, 1'b0, 1'b1, 32'hFF0F0F0F, 1'b0, 1'b1);
      en = 1'b0; A = 32'h00000000; B = 32'h00000001;
      @(posedge clk); #1;
      expect_resp("hold", 32'h00000001, 1'b0, 1'b0, 1'b1, 32'hFF0F0F0F, 1'b0, 1'b0);

      // Load a zero result: zero_q follows.
      en = 1'b1; A = 32'h0; B = 32'h0;
      @(posedge clk); #1;
      expect_resp("load_zero", 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);

      // Load, then async reset between edges.
      A = 32'h12340000; B = 32'h00005678;
      @(posedge clk); #1;
      expect_resp("load2", 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      expect_resp("async_rst", 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
      @(posedge clk); #1;
      expect_resp("rst_held", 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);

      // First load after reset release.
      #2;
      rst = 1'b0;
      A = 32'h80000001; B = 32'h00010000;
      @(posedge clk); #1;
      expect_resp("post_rst_load", 32'h80010001, 1'b0, 1'b0, 1'b1,
                  32'h80010001, 1'b0, 1'b1);
      en = 1'b0;
      @(posedge clk); #1;
      expect_resp("post_rst_idle", 32'h80010001, 1'b0, 1'b0, 1'b1,
                  32'h80010001, 1'b0, 1'b0);

      #5;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
